// File: rtl/glitc_trigger_generator.sv
// GLITC trigger generator: two-stage threshold/coincidence pipeline feeding a
// holdoff state machine, with a small four-register user port.
module glitc_trigger_generator (
    input  logic        sysclk_i,
    input  logic        rst_i,
    input  logic        sync_i,
    input  logic [10:0] r0_power_i,
    input  logic [10:0] r1_power_i,
    input  logic [10:0] phi_down_power_i,
    input  logic [10:0] phi_up_power_i,
    input  logic        phi_down_valid_i,
    input  logic        phi_up_valid_i,
    input  logic        user_wr_i,
    input  logic [1:0]  user_addr_i,
    input  logic [31:0] user_dat_i,
    output logic [31:0] user_dat_o,
    output logic        trig_o,
    output logic [3:0]  trig_src_o,
    output logic        trig_phase_o
);

    typedef enum logic {IDLE = 1'b0, HOLDOFF = 1'b1} state_t;

    logic [10:0] thr0_q, thr1_q;
    logic        en_q, mode_q;
    logic [7:0]  hold_cfg_q;
    logic [3:0]  win_cfg_q;
    logic [31:0] count_q;
    logic [31:0] rd_mux, dat_q;

    logic        h0_q, h1_q, hd_q, hu_q;
    logic [3:0]  wdn_q, wup_q;
    logic        down_open, up_open, fire;

    state_t      state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic        trig_q, trig_d;
    logic [3:0]  src_q, src_d;
    logic        phase_q, phase_d;

    logic        unused_dat;
    assign unused_dat = &user_dat_i[31:27];

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            thr0_q     <= 11'h7FF;
            thr1_q     <= 11'h7FF;
            en_q       <= 1'b0;
            mode_q     <= 1'b0;
            hold_cfg_q <= '0;
            win_cfg_q  <= '0;
        end else if (user_wr_i) begin
            case (user_addr_i)
                2'd0: begin
                    thr0_q <= user_dat_i[10:0];
                    thr1_q <= user_dat_i[26:16];
                end
                2'd1: begin
                    en_q       <= user_dat_i[0];
                    mode_q     <= user_dat_i[1];
                    hold_cfg_q <= user_dat_i[15:8];
                    win_cfg_q  <= user_dat_i[19:16];
                end
                default: ;
            endcase
        end
    end

    // A clear write beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge sysclk_i) begin
        if (rst_i || (user_wr_i && user_addr_i == 2'd2)) begin
            count_q <= '0;
        end else if (trig_q && count_q != 32'hFFFF_FFFF) begin
            count_q <= count_q + 32'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (user_addr_i)
            2'd0: rd_mux = {5'b0, thr1_q, 5'b0, thr0_q};
            2'd1: rd_mux = {12'b0, win_cfg_q, hold_cfg_q, 6'b0, mode_q, en_q};
            2'd2: rd_mux = count_q;
            2'd3: rd_mux = {26'b0, phase_q, (state_q == HOLDOFF), src_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) dat_q <= '0;
        else       dat_q <= rd_mux;
    end

    // Stage 1: registered local and neighbour threshold hits.
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            h0_q <= 1'b0;
            h1_q <= 1'b0;
            hd_q <= 1'b0;
            hu_q <= 1'b0;
        end else begin
            h0_q <= (r0_power_i > thr0_q);
            h1_q <= (r1_power_i > thr1_q);
            hd_q <= phi_down_valid_i && (phi_down_power_i > thr0_q);
            hu_q <= phi_up_valid_i && (phi_up_power_i > thr1_q);
        end
    end

    // Loading from the registered hit keeps a neighbour open for exactly
    // 'window' cycles beyond the hit cycle itself.
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            wdn_q <= '0;
            wup_q <= '0;
        end else begin
            if (hd_q)              wdn_q <= win_cfg_q;
            else if (wdn_q != 4'd0) wdn_q <= wdn_q - 4'd1;
            if (hu_q)              wup_q <= win_cfg_q;
            else if (wup_q != 4'd0) wup_q <= wup_q - 4'd1;
        end
    end

    // Stage 2: decision and holdoff state machine.
    assign down_open = hd_q || (wdn_q != 4'd0);
    assign up_open   = hu_q || (wup_q != 4'd0);
    assign fire      = (h0_q || h1_q) && (!mode_q || down_open || up_open);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        trig_d  = 1'b0;
        src_d   = src_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (en_q && fire) begin
                    trig_d  = 1'b1;
                    src_d   = {up_open, down_open, h1_q, h0_q};
                    phase_d = sync_i;
                    // A zero holdoff stays in IDLE so back-to-back triggers are possible.
                    if (hold_cfg_q != 8'd0) begin
                        state_d = HOLDOFF;
                        hcnt_d  = hold_cfg_q;
                    end
                end
            end
            HOLDOFF: begin
                if (hcnt_q == 8'd0) state_d = IDLE;
                else                hcnt_d  = hcnt_q - 8'd1;
            end
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            trig_q  <= 1'b0;
            src_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            trig_q  <= trig_d;
            src_q   <= src_d;
            phase_q <= phase_d;
        end
    end

    assign user_dat_o   = dat_q;
    assign trig_o       = trig_q;
    assign trig_src_o   = src_q;
    assign trig_phase_o = phase_q;

endmodule

// File: tb/tb_glitc_trigger_generator.sv
// Self-checking bench for glitc_trigger_generator: vector table, directed
// multi-cycle sequences and randomized traffic against a cycle-list model.
module tb_glitc_trigger_generator;

    logic        clk = 1'b0;
    always #3 clk = ~clk;

    logic        rst, sync;
    logic [10:0] r0, r1, pd, pu;
    logic        vd, vu;
    logic        uwr;
    logic [1:0]  uaddr;
    logic [31:0] udat, udat_o;
    logic        trig, phase;
    logic [3:0]  src;

    glitc_trigger_generator dut (
        .sysclk_i(clk), .rst_i(rst), .sync_i(sync),
        .r0_power_i(r0), .r1_power_i(r1),
        .phi_down_power_i(pd), .phi_up_power_i(pu),
        .phi_down_valid_i(vd), .phi_up_valid_i(vu),
        .user_wr_i(uwr), .user_addr_i(uaddr), .user_dat_i(udat), .user_dat_o(udat_o),
        .trig_o(trig), .trig_src_o(src), .trig_phase_o(phase)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [10:0] r0;
        logic [10:0] r1;
        logic        exp_trig;
        logic [3:0]  exp_src;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c,
                          input logic d, input logic [10:0] e, input logic f);
        r0 = a; r1 = b; pd = c; vd = d; pu = e; vu = f;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        uwr = 1'b1; uaddr = a; udat = d;
        step();
        uwr = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        uaddr = a;
        step();
        check(name, udat_o, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; sync = 1'b0; uwr = 1'b0; uaddr = 2'd0; udat = '0;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    // Local hit on r0 at input step t_loc, down-neighbour hit at t_hd.
    task automatic run_coinc(input string name, input int t_hd, input int t_loc,
                             input logic v, input logic expect_trig, input logic [3:0] exp_src);
        for (int i = 0; i < 8; i++) begin
            set_in((i == t_loc) ? 11'd150 : 11'd0, 0, (i == t_hd) ? 11'd150 : 11'd0,
                   (i == t_hd) ? v : 1'b0, 0, 0);
            step();
            check(name, 32'(trig), 32'(expect_trig && (i == t_loc + 1)));
            if (expect_trig && (i == t_loc + 1)) check({name, "_src"}, 32'(src), 32'(exp_src));
        end
        idle(5);
    endtask

    initial begin
        int exp_cnt;

        tbl[0] = '{11'd101,  11'd0,    1'b1, 4'b0001};
        tbl[1] = '{11'd100,  11'd0,    1'b0, 4'b0000};
        tbl[2] = '{11'd0,    11'd201,  1'b1, 4'b0010};
        tbl[3] = '{11'd0,    11'd200,  1'b0, 4'b0000};
        tbl[4] = '{11'd2047, 11'd2047, 1'b1, 4'b0011};
        tbl[5] = '{11'd0,    11'd0,    1'b0, 4'b0000};
        tbl[6] = '{11'd99,   11'd250,  1'b1, 4'b0010};
        tbl[7] = '{11'd101,  11'd200,  1'b1, 4'b0001};

        // Reset state
        rst = 1'b1; sync = 1'b0; uwr = 1'b0; uaddr = 2'd0; udat = '0;
        set_in(0, 0, 0, 0, 0, 0);
        step(); step();
        check("rst_trig", 32'(trig), 0);
        check("rst_src", 32'(src), 0);
        check("rst_phase", 32'(phase), 0);
        check("rst_udat", udat_o, 0);
        rst = 1'b0;
        chk_rd("rst_thresh", 2'd0, 32'h07FF_07FF);
        chk_rd("rst_ctrl", 2'd1, 32'h0);
        chk_rd("rst_count", 2'd2, 32'h0);
        chk_rd("rst_status", 2'd3, 32'h0);

        // Reset thresholds block even a full-scale input once enabled
        wr(2'd1, 32'h0000_0001);
        set_in(2047, 2047, 0, 0, 0, 0); step();
        idle(1);
        check("rst_thr_blocks", 32'(trig), 0);

        // Vector table: thresholds 100 / 200, mode 0, holdoff 0
        wr(2'd0, 32'h00C8_0064);
        exp_cnt = 0;
        foreach (tbl[k]) begin
            set_in(tbl[k].r0, tbl[k].r1, 0, 0, 0, 0);
            step();
            set_in(0, 0, 0, 0, 0, 0);
            step();
            check($sformatf("vec%0d_trig", k), 32'(trig), 32'(tbl[k].exp_trig));
            if (tbl[k].exp_trig) begin
                check($sformatf("vec%0d_src", k), 32'(src), 32'(tbl[k].exp_src));
                exp_cnt++;
            end
            step();
            check($sformatf("vec%0d_pulse", k), 32'(trig), 0);
        end
        idle(2);
        chk_rd("vec_count", 2'd2, 32'(exp_cnt));

        // Phase capture
        sync = 1'b1;
        set_in(101, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0); step();
        check("phase_trig", 32'(trig), 1);
        check("phase_val", 32'(phase), 1);
        sync = 1'b0;
        idle(1);
        chk_rd("phase_status", 2'd3, 32'h21);

        // Holdoff = 5 with r1 hot for 10 cycles
        do_reset();
        wr(2'd0, 32'h00C8_0064);
        wr(2'd1, 32'h0000_0501);
        for (int i = 0; i < 13; i++) begin
            if (i < 10) set_in(0, 201, 0, 0, 0, 0);
            else        set_in(0, 0, 0, 0, 0, 0);
            step();
            check($sformatf("hold5_s%0d", i), 32'(trig), 32'(i == 1 || i == 8));
            if (i == 1 || i == 8) check("hold5_src", 32'(src), 32'h2);
        end
        idle(10);
        chk_rd("hold5_status", 2'd3, 32'h02);

        // CTRL rewrite during holdoff does not reload the running count
        do_reset();
        wr(2'd0, 32'h00C8_0064);
        wr(2'd1, 32'h0000_0501);
        for (int i = 0; i < 16; i++) begin
            set_in(0, 201, 0, 0, 0, 0);
            if (i == 2) begin uwr = 1'b1; uaddr = 2'd1; udat = 32'h0000_0101; end
            else        uwr = 1'b0;
            step();
            check($sformatf("reload_s%0d", i), 32'(trig), 32'(i == 1 || i == 8 || i == 11 || i == 14));
        end
        uwr = 1'b0;

        // Disable during holdoff: holdoff completes, nothing fires until re-enabled
        do_reset();
        wr(2'd0, 32'h00C8_0064);
        wr(2'd1, 32'h0000_0501);
        for (int i = 0; i < 20; i++) begin
            set_in(0, 201, 0, 0, 0, 0);
            if (i == 3) begin uwr = 1'b1; uaddr = 2'd1; udat = 32'h0; end
            else        uwr = 1'b0;
            step();
            check($sformatf("disable_s%0d", i), 32'(trig), 32'(i == 1));
        end
        uwr = 1'b0;
        chk_rd("disable_status", 2'd3, 32'h02);
        wr(2'd1, 32'h0000_0001);
        step();
        check("reenable_trig", 32'(trig), 1);
        idle(3);

        // Coincidence: mode 1, window 3, thresholds 100 / 100
        do_reset();
        wr(2'd0, 32'h0064_0064);
        wr(2'd1, 32'h0003_0003);
        idle(2);
        run_coinc("coinc_t3", 0, 3, 1'b1, 1'b1, 4'b0101);
        run_coinc("coinc_t4", 0, 4, 1'b1, 1'b0, 4'b0000);
        run_coinc("coinc_novalid", 0, 0, 1'b0, 1'b0, 4'b0000);
        run_coinc("coinc_same", 0, 0, 1'b1, 1'b1, 4'b0101);
        run_coinc("coinc_late_nb", 2, 0, 1'b1, 1'b0, 4'b0000);
        set_in(0, 150, 0, 0, 150, 1); step();
        set_in(0, 0, 0, 0, 0, 0); step();
        check("coinc_up_trig", 32'(trig), 1);
        check("coinc_up_src", 32'(src), 32'hA);
        idle(5);

        // COUNT clear on the same cycle as a trigger
        do_reset();
        wr(2'd0, 32'h0064_0064);
        wr(2'd1, 32'h0000_0001);
        set_in(101, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0); step();
        check("clr_trig", 32'(trig), 1);
        wr(2'd2, 32'h0);
        idle(1);
        chk_rd("clr_count", 2'd2, 32'h0);

        // COUNT saturation
        force dut.count_q = 32'hFFFF_FFFF;
        step();
        release dut.count_q;
        chk_rd("sat_preload", 2'd2, 32'hFFFF_FFFF);
        set_in(101, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0); step();
        check("sat_trig", 32'(trig), 1);
        idle(2);
        chk_rd("sat_count", 2'd2, 32'hFFFF_FFFF);

        // Reset in the middle of a long holdoff
        do_reset();
        wr(2'd0, 32'h0064_0064);
        wr(2'd1, 32'h0000_C801);
        set_in(101, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0); step();
        check("midrst_trig", 32'(trig), 1);
        idle(3);
        chk_rd("midrst_status", 2'd3, 32'h11);
        idle(4);
        rst = 1'b1; step();
        check("midrst_trig0", 32'(trig), 0);
        check("midrst_src0", 32'(src), 0);
        check("midrst_phase0", 32'(phase), 0);
        check("midrst_udat0", udat_o, 0);
        rst = 1'b0;
        chk_rd("midrst_thresh", 2'd0, 32'h07FF_07FF);
        chk_rd("midrst_ctrl", 2'd1, 32'h0);
        chk_rd("midrst_status0", 2'd3, 32'h0);
        wr(2'd0, 32'h0064_0064);
        set_in(101, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0); step();
        check("midrst_disabled", 32'(trig), 0);
        wr(2'd1, 32'h0000_0001);
        set_in(101, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0); step();
        check("midrst_reenabled", 32'(trig), 1);
        idle(2);

        // Randomized traffic against an event-list model
        for (int ph = 0; ph < 4; ph++) begin
            int thr0, thr1, win, hold, gap, last_trig, last_hd, last_hu, cnt;
            logic mode, trig_prev, trig_cur;
            logic [3:0] src_prev, src_cur;
            thr0 = $urandom_range(200, 50);
            thr1 = $urandom_range(200, 50);
            win  = $urandom_range(5, 0);
            case ($urandom_range(4, 0))
                0: hold = 0;
                1: hold = 1;
                2: hold = 2;
                3: hold = 3;
                default: hold = 7;
            endcase
            mode = 1'($urandom_range(1, 0));
            do_reset();
            wr(2'd0, {5'b0, 11'(thr1), 5'b0, 11'(thr0)});
            wr(2'd1, {12'b0, 4'(win), 8'(hold), 6'b0, mode, 1'b1});
            idle(2);
            gap = (hold == 0) ? 1 : hold + 2;
            last_trig = -1000; last_hd = -1000; last_hu = -1000; cnt = 0;
            trig_prev = 1'b0; src_prev = 4'h0; src_cur = 4'h0;
            for (int j = 0; j < 300; j++) begin
                int a, b, c, e;
                logic vdd, vuu, h0, h1, hd, hu, dopen, uopen;
                a = $urandom_range(thr0 + 20, 0);
                b = $urandom_range(thr1 + 20, 0);
                c = $urandom_range(thr0 + 60, 0);
                e = $urandom_range(thr1 + 60, 0);
                vdd = 1'($urandom_range(1, 0));
                vuu = 1'($urandom_range(1, 0));
                set_in(11'(a), 11'(b), 11'(c), vdd, 11'(e), vuu);
                h0 = a > thr0;
                h1 = b > thr1;
                hd = vdd && (c > thr0);
                hu = vuu && (e > thr1);
                if (hd) last_hd = j;
                if (hu) last_hu = j;
                dopen = (j - last_hd) <= win;
                uopen = (j - last_hu) <= win;
                trig_cur = 1'b0;
                if ((h0 || h1) && (!mode || dopen || uopen) && (j - last_trig) >= gap) begin
                    trig_cur  = 1'b1;
                    src_cur   = {uopen, dopen, h1, h0};
                    last_trig = j;
                    cnt++;
                end
                step();
                check($sformatf("rnd%0d_trig_%0d", ph, j), 32'(trig), 32'(trig_prev));
                check($sformatf("rnd%0d_src_%0d", ph, j), 32'(src), 32'(src_prev));
                trig_prev = trig_cur;
                src_prev  = src_cur;
            end
            idle(1);
            check($sformatf("rnd%0d_trig_last", ph), 32'(trig), 32'(trig_prev));
            idle(2);
            chk_rd($sformatf("rnd%0d_count", ph), 2'd2, 32'(cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
